// File: rtl/dlx_isa_pkg.sv
// Shared DLX ISA table: request kinds, loader states, opcode/func constants and legality checks.
// Used by both the instruction encoder and the control decoder so the two agree on one ISA table.
package dlx_isa_pkg;

    typedef enum logic [1:0] {
        KIND_R   = 2'd0,
        KIND_I   = 2'd1,
        KIND_J   = 2'd2,
        KIND_END = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_RFP   = 6'd1;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQZ  = 6'd4;
    localparam logic [5:0] OP_BNEZ  = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [10:0] FN_SLL  = 11'd4;
    localparam logic [10:0] FN_MULT = 11'd14;
    localparam logic [10:0] FN_ADD  = 11'd32;
    localparam logic [10:0] FN_SUB  = 11'd34;
    localparam logic [10:0] FN_AND  = 11'd36;
    localparam logic [10:0] FN_OR   = 11'd37;

    function automatic logic is_legal_r(input logic [10:0] func);
        case (func) inside
            11'd4, 11'd6, 11'd7, 11'd14, 11'd21, 11'd22,
            [11'd32:11'd38], [11'd40:11'd45], 11'd52, 11'd53: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_i(input logic [5:0] op);
        case (op) inside
            6'd4, 6'd5, [6'd8:6'd15], [6'd18:6'd20], [6'd22:6'd29],
            6'd32, 6'd33, [6'd35:6'd37], 6'd40, 6'd41, 6'd43: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_j(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

    // Multiply/divide-class R functions execute on the FP unit and carry opcode 1.
    function automatic logic [5:0] r_opcode(input logic [10:0] func);
        case (func)
            11'd14, 11'd22, 11'd52, 11'd53: return OP_RFP;
            default: return OP_RTYPE;
        endcase
    endfunction

endpackage

// File: rtl/dlx_field_pack.sv
// Combinational field packer: turns one request's fields into a 32-bit DLX word plus a legality flag.
module dlx_field_pack
    import dlx_isa_pkg::*;
(
    input  kind_e        kind,
    input  logic [5:0]   op,
    input  logic [10:0]  func,
    input  logic [4:0]   rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [25:0]  imm,
    output logic [31:0]  word,
    output logic         legal
);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (kind)
            KIND_R: begin
                word  = {r_opcode(func), rs2, rs1, rd, func};
                legal = is_legal_r(func);
            end
            KIND_I: begin
                word  = {op, rs1, rd, imm[15:0]};
                legal = is_legal_i(op);
            end
            KIND_J: begin
                word  = {op, imm};
                legal = is_legal_j(op);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dlx_instr_encoder.sv
// Instruction-memory loader: accepts field-level requests, encodes them, and writes one word per cycle
// from a base address, with session FSM, word counter and sticky first-error capture.
module dlx_instr_encoder
    import dlx_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [5:0]        in_op,
    input  logic [10:0]       in_func,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [25:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err,
    output logic [ADDR_W:0]   err_index
);

    localparam logic [ADDR_W:0] MAX_C = (ADDR_W + 1)'(MAX_WORDS);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic [ADDR_W:0]   req_count_q, req_count_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   err_index_q, err_index_d;

    kind_e             kind;
    logic [31:0]       pack_word;
    logic              pack_legal;
    logic              accept;
    logic [ADDR_W:0]   wc_pend;
    logic [ADDR_W:0]   wc_inc;
    logic [ADDR_W-1:0] wr_addr;

    assign kind = kind_e'(in_kind);

    dlx_field_pack u_pack (
        .kind  (kind),
        .op    (in_op),
        .func  (in_func),
        .rd    (in_rd),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .imm   (in_imm),
        .word  (pack_word),
        .legal (pack_legal)
    );

    // The counters commit a word when its write cycle ends, so a write still in the output
    // register must be counted both for back-pressure and for the next write address.
    assign wc_pend  = word_count_q + (ADDR_W + 1)'(we_q);
    assign wc_inc   = word_count_q + (ADDR_W + 1)'(1);
    assign wr_addr  = addr_cnt_q + ADDR_W'(we_q);
    assign in_ready = (state_q == ST_LOAD) && (wc_pend < MAX_C);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        addr_cnt_d   = addr_cnt_q;
        word_count_d = word_count_q;
        req_count_d  = req_count_q;
        err_d        = err_q;
        err_index_d  = err_index_q;

        if (we_q) begin
            addr_cnt_d   = addr_cnt_q + ADDR_W'(1);
            word_count_d = wc_inc;
            if (wc_inc == MAX_C) state_d = ST_DONE;
        end

        if (accept) begin
            req_count_d = req_count_q + (ADDR_W + 1)'(1);
            if (kind == KIND_END) begin
                state_d = ST_DONE;
            end else if (pack_legal) begin
                we_d    = 1'b1;
                addr_d  = wr_addr;
                wdata_d = pack_word;
            end else begin
                err_d = 1'b1;
                if (!err_q) err_index_d = req_count_q;
            end
        end

        if (start && (state_q != ST_LOAD)) begin
            state_d      = ST_LOAD;
            addr_cnt_d   = base_addr;
            word_count_d = '0;
            req_count_d  = '0;
            err_d        = 1'b0;
            err_index_d  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            addr_cnt_q   <= '0;
            word_count_q <= '0;
            req_count_q  <= '0;
            err_q        <= 1'b0;
            err_index_q  <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            addr_cnt_q   <= addr_cnt_d;
            word_count_q <= word_count_d;
            req_count_q  <= req_count_d;
            err_q        <= err_d;
            err_index_q  <= err_index_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == ST_LOAD);
    assign done       = (state_q == ST_DONE);
    assign word_count = word_count_q;
    assign err        = err_q;
    assign err_index  = err_index_q;

endmodule

// File: tb/tb_dlx_instr_encoder.sv
// Scoreboard bench for dlx_instr_encoder: directed requests push expected writes; a monitor pops and compares.
module tb_dlx_instr_encoder;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [5:0]        in_op;
    logic [10:0]       in_func;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [25:0]       in_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic              err;
    logic [ADDR_W:0]   err_index;

    dlx_instr_encoder #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_op      (in_op),
        .in_func    (in_func),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .err        (err),
        .err_index  (err_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   wr_cyc_last = 0;
    int   wr_cyc_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_cyc_prev = wr_cyc_last;
            wr_cyc_last = cyc;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%02h data 0x%08h, want no write", imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
            end
        end
    end

    task automatic pulse_start(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] kind, input logic [5:0] op, input logic [10:0] func,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [25:0] imm, input bit wr, input logic [ADDR_W-1:0] ea,
                        input logic [31:0] ew);
        bit ok = 1'b0;
        in_kind  = kind;
        in_op    = op;
        in_func  = func;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                if (wr) exp_q.push_back('{addr: ea, data: ew});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   32'd0);
        check({tag, "_imem_we"},    32'(imem_we),    32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err"},        32'(err),        32'd0);
        check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
        check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
        check({tag, "_err_index"},  32'(err_index),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_kind = '0; in_op = '0; in_func = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("rst");

        // 1: R add, then END while its write is still pending; in_op must be ignored for R.
        pulse_start(8'h10);
        check("t1_busy", 32'(busy), 32'd1);
        send(2'd0, 6'h3F, 11'd32, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1, 8'h10, 32'h0041_1820);
        send(2'd3, 6'd0, 11'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 8'h00, 32'h0);
        wait_done();
        check("t1_word_count", 32'(word_count), 32'd1);
        check("t1_done", 32'(done), 32'd1);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // 2: lw then jal back-to-back.
        pulse_start(8'h20);
        send(2'd1, 6'd35, 11'd0, 5'd5, 5'd6, 5'd0, 26'h0000004, 1'b1, 8'h20, 32'h8CC5_0004);
        send(2'd2, 6'd3, 11'd0, 5'd0, 5'd0, 5'd0, 26'h0000100, 1'b1, 8'h21, 32'h0C00_0100);
        send(2'd3, 6'd0, 11'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 8'h00, 32'h0);
        wait_done();
        check("t2_consecutive", 32'(wr_cyc_last - wr_cyc_prev), 32'd1);
        check("t2_word_count", 32'(word_count), 32'd2);
        check("t2_hold_addr", 32'(imem_addr), 32'h21);
        check("t2_hold_data", imem_wdata, 32'h0C00_0100);
        check("t2_we_in_done", 32'(imem_we), 32'd0);

        // 3: R mult selects opcode 1.
        pulse_start(8'h30);
        send(2'd0, 6'd0, 11'd14, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 8'h30, 32'h0462_080E);
        send(2'd3, 6'd0, 11'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 8'h00, 32'h0);
        wait_done();
        check("t3_word_count", 32'(word_count), 32'd1);

        // 4: addi (imm[25:16] ignored), illegal R func 15, addi, illegal J op 4, END.
        pulse_start(8'h40);
        send(2'd1, 6'd8, 11'd0, 5'd1, 5'd0, 5'd0, 26'h3FF_0005, 1'b1, 8'h40, 32'h2001_0005);
        send(2'd0, 6'd0, 11'd15, 5'd1, 5'd1, 5'd1, 26'd0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        check("t4_ready_after_illegal", 32'(in_ready), 32'd1);
        check("t4_err", 32'(err), 32'd1);
        check("t4_err_index", 32'(err_index), 32'd1);
        @(posedge clk);
        #1;
        send(2'd1, 6'd8, 11'd0, 5'd2, 5'd1, 5'd0, 26'h000_FFFF, 1'b1, 8'h41, 32'h2022_FFFF);
        send(2'd2, 6'd4, 11'd0, 5'd0, 5'd0, 5'd0, 26'h0000010, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        check("t4_err_index_first", 32'(err_index), 32'd1);
        check("t4_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(2'd3, 6'd0, 11'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 8'h00, 32'h0);
        wait_done();
        check("t4_word_count", 32'(word_count), 32'd2);
        check("t4_err_sticky", 32'(err), 32'd1);

        // 5: four J writes wrap past the top of the address space, then MAX_WORDS stops intake.
        pulse_start(8'hFE);
        check("t5_err_cleared", 32'(err), 32'd0);
        check("t5_err_index_cleared", 32'(err_index), 32'd0);
        check("t5_wc_cleared", 32'(word_count), 32'd0);
        send(2'd2, 6'd2, 11'd0, 5'd0, 5'd0, 5'd0, 26'd1, 1'b1, 8'hFE, 32'h0800_0001);
        send(2'd2, 6'd2, 11'd0, 5'd0, 5'd0, 5'd0, 26'd2, 1'b1, 8'hFF, 32'h0800_0002);
        send(2'd2, 6'd2, 11'd0, 5'd0, 5'd0, 5'd0, 26'd3, 1'b1, 8'h00, 32'h0800_0003);
        send(2'd2, 6'd2, 11'd0, 5'd0, 5'd0, 5'd0, 26'd4, 1'b1, 8'h01, 32'h0800_0004);
        in_kind = 2'd2; in_op = 6'd2; in_imm = 26'd5; in_valid = 1'b1;
        @(negedge clk);
        check("t5_ready_full", 32'(in_ready), 32'd0);
        wait_done();
        check("t5_word_count", 32'(word_count), 32'd4);
        check("t5_last_addr", 32'(imem_addr), 32'h01);
        in_imm = 26'd6;
        repeat (4) @(negedge clk);
        check("t5_ready_done", 32'(in_ready), 32'd0);
        check("t5_we_done", 32'(imem_we), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;

        // 6: start mid-LOAD ignored, then reset while a write is pending.
        pulse_start(8'h50);
        send(2'd1, 6'd8, 11'd0, 5'd1, 5'd0, 5'd0, 26'h0000011, 1'b1, 8'h50, 32'h2001_0011);
        pulse_start(8'h70);
        send(2'd1, 6'd8, 11'd0, 5'd2, 5'd0, 5'd0, 26'h0000022, 1'b1, 8'h51, 32'h2002_0022);
        send(2'd1, 6'd8, 11'd0, 5'd3, 5'd0, 5'd0, 26'h0000033, 1'b1, 8'h52, 32'h2003_0033);
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_word_count", 32'(word_count), 32'd2);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("t6");
        repeat (3) @(negedge clk);
        check("t6_still_idle", 32'(busy | done | imem_we), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
